approx_seq_div: RTL and testbench
=================================

# approx_seq_div

Iterative unsigned radix-2 restoring divider, the inverse operator to the recursive approximate multiplier in the multiplier library. It computes quotient and remainder of two W-bit operands over several clock cycles using a start/done handshake. Setting the approximation parameter skips the K least-significant quotient iterations, which trades accuracy for latency. It is intended for the same accuracy/energy exploration flows as the approximate multipliers.

## Interface
Parameters:
- W, 8: operand width; W ≥ 2.
- K, 0: number of skipped LSB quotient iterations; 0 ≤ K ≤ W-1; K = 0 gives exact division.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous and active-high.
- start  input  1  request; sampled only in IDLE.
- dividend  input  W  unsigned dividend a; sampled with start.
- divisor  input  W  unsigned divisor b; sampled with start.
- busy  output  1  high while iterating (CALC).
- done  output  1  one-cycle pulse; quotient, remainder and div_by_zero are valid.
- quotient  output  W  result q.
- remainder  output  W  result r.
- div_by_zero  output  1  last accepted operation had b = 0.

## Operation
- The FSM has three states: IDLE, CALC, DONE.
- IDLE, start=1, b≠0: latch b. Load R=0 and Q=a. Load the iteration counter with W-K. Go to CALC.
- IDLE, start=1, b=0: go to DONE and set quotient = all ones, remainder = a, div_by_zero = 1.
- CALC, per edge:
  - Shift {R,Q} left by 1.
  - Form the trial value T = R_shifted - b at W+1 bits.
  - If T ≥ 0: R ← T[W-1:0] and Q[0] ← 1. Otherwise R ← R_shifted and Q[0] ← 0.
  - Decrement the counter. When it reaches 0, go to DONE.
- Result on entry to DONE (b≠0):
  - quotient = Q[W-K-1:0] << K, which equals floor((a>>K)/b)·2^K.
  - remainder = R, which equals (a>>K) mod b.
  - div_by_zero = 0.
  - For K = 0 these are exact: floor(a/b) and a mod b.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start is ignored in CALC and DONE; no queuing. Operand changes while not in IDLE have no effect.
- quotient, remainder and div_by_zero are registered. They hold their last value until the next result is written.
- The partial remainder datapath is W+1 bits wide internally. No intermediate value overflows for any a and b.

## Timing
- Reset (rst=1 at an edge) forces IDLE and clears busy, done, quotient, remainder and div_by_zero to 0. Reset has priority over everything, including start on the same edge.
- Reset during CALC or DONE aborts the operation. No done is issued and the outputs are cleared.
- Cycle numbering: start is accepted at edge 0, and cycle n is the cycle after edge n-1 plus one (the cycle following edge 0 is cycle 1).
- Normal operation (b≠0):
  - busy = 1 in cycles 1..W-K.
  - done = 1 in cycle W-K+1 only.
  - Latency is W-K+1 cycles and throughput is one operation per W-K+2 cycles.
- Divide by zero: done = 1 in cycle 1, busy stays 0, and throughput is one per 2 cycles.
- busy and done are never high together.
- start held high continuously is accepted on every IDLE edge. The first re-acceptance is at the edge ending the DONE cycle + 1, that is, in IDLE.

## Test plan
- W=8, K=0, a=200, b=7, start pulse at edge 0 -> busy in cycles 1–8; done in cycle 9 with q=28, r=4, div_by_zero=0.
- W=8, K=0: a=255, b=1 -> q=255, r=0. Then a=5, b=9 -> q=0, r=5. Then a=255, b=255 -> q=1, r=0.
- W=8, K=0, a=7, b=0 -> done in cycle 1, busy never high, q=255, r=7, div_by_zero=1. A following a=9, b=3 clears the flag and gives q=3, r=0.
- W=8, K=2, a=200, b=7 -> done in cycle 7 with q=28, r=1. Also a=13, b=2 -> q=4, r=1 (exact quotient would be 6).
- W=8, K=0, start a=100, b=3; raise start again with a=1, b=1 in cycle 4; assert rst in cycle 6 -> the second start is ignored; after reset, done never pulses and all outputs are 0. A new start a=100, b=3 then gives q=33, r=1.
- Randomized check, K=0, W=8, 1000 operand pairs with b≠0 -> q·b + r = a and r < b for every pair. For K>0, q equals floor((a>>K)/b)<<K for every pair.

Source files
------------

// File: rtl/approx_seq_div.sv
// -----------------------------------------------------------------------------
// approx_seq_div
//
// Iterative unsigned radix-2 restoring divider with an approximation parameter.
// One quotient bit is resolved per clock in CALC. Setting K > 0 skips the K
// least-significant quotient iterations. The result is then the quotient of
// (a >> K) / b, scaled back up by 2^K, and the remainder of (a >> K) mod b.
//
// Parameters:
//   W  operand width (W >= 2)
//   K  skipped LSB quotient iterations (0 <= K <= W-1), K = 0 is exact
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start        operation request, sampled only in IDLE
//   dividend     unsigned dividend a, sampled with start
//   divisor      unsigned divisor b, sampled with start
//   busy         high while iterating (CALC)
//   done         one-cycle pulse; quotient/remainder/div_by_zero are valid
//   quotient     registered quotient
//   remainder    registered remainder
//   div_by_zero  last accepted operation had b = 0
// -----------------------------------------------------------------------------
module approx_seq_div #(
  parameter int W = 8,
  parameter int K = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW   = $clog2(W + 1);
  localparam int ITER = W - K;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   rem_q, rem_d;        // partial remainder, always < b
  logic [W-1:0]   quo_q, quo_d;        // dividend bits shifting out, quotient bits in
  logic [W-1:0]   b_q, b_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   quotient_q, quotient_d;
  logic [W-1:0]   remainder_q, remainder_d;
  logic           dbz_q, dbz_d;

  // One restoring step. The shifted remainder needs W+1 bits because
  // 2*R + 1 can reach 2b - 1.
  logic [W:0]     r_shift;
  logic [W-1:0]   r_diff;
  logic           fits;
  logic [W-1:0]   r_step;
  logic [W-1:0]   q_step;

  always_comb begin
    r_shift = {rem_q, quo_q[W-1]};
    fits    = (r_shift >= {1'b0, b_q});
    // When the subtraction is kept, the true difference is < b < 2^W,
    // so computing it modulo 2^W is exact.
    r_diff  = r_shift[W-1:0] - b_q;
    r_step  = fits ? r_diff : r_shift[W-1:0];
    q_step  = {quo_q[W-2:0], fits};
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case statement can leave a signal unassigned and infer a latch.
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end else begin
            b_d     = divisor;
            rem_d   = '0;
            quo_d   = dividend;
            cnt_d   = CW'(ITER);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = r_step;
        quo_d = q_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // After W-K shifts the low W-K bits hold the quotient of a>>K and
          // the top K bits still hold the unused low dividend bits; shifting
          // left by K drops those and rescales the quotient.
          quotient_d  = q_step << K;
          remainder_d = r_step;
          dbz_d       = 1'b0;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the values from before this edge, independent of statement order.
  // The datapath registers are cleared too, so a reset run is fully deterministic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_approx_seq_div.sv
// -----------------------------------------------------------------------------
// tb_approx_seq_div
//
// Bench for approx_seq_div. There are two instances, one exact (K=0) and one
// approximate (K=2). The bench applies a table of directed operations, then
// hand-written reset-abort and back-to-back sequences. It finishes with
// randomized operands checked against plain integer division.
// -----------------------------------------------------------------------------
module tb_approx_seq_div;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start0, start2;
  logic [W-1:0] dividend, divisor;
  logic         busy0, done0, dbz0;
  logic         busy2, done2, dbz2;
  logic [W-1:0] q0, r0, q2, r2;

  always #5 clk = ~clk;

  approx_seq_div #(.W(W), .K(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .dividend(dividend), .divisor(divisor),
    .busy(busy0), .done(done0), .quotient(q0), .remainder(r0), .div_by_zero(dbz0)
  );

  approx_seq_div #(.W(W), .K(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .dividend(dividend), .divisor(divisor),
    .busy(busy2), .done(done2), .quotient(q2), .remainder(r2), .div_by_zero(dbz2)
  );

  int tests_run = 0;
  int fails     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Starts one operation on the selected instance (sel 0 -> K=0, 2 -> K=2).
  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  // Returns the done cycle (-1 on timeout), the number of busy cycles seen,
  // and how often busy and done were high together.
  task automatic do_op(input int sel, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                       output int lat, output int nbusy, output int overlap);
    logic bz, dn;
    dividend = a;
    divisor  = b;
    if (sel == 2) start2 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start2 = 1'b0;
    lat = -1; nbusy = 0; overlap = 0;
    q = '0; r = '0; z = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      bz = (sel == 2) ? busy2 : busy0;
      dn = (sel == 2) ? done2 : done0;
      if (bz) nbusy++;
      if (bz && dn) overlap++;
      if (dn) begin
        lat = n;
        q = (sel == 2) ? q2 : q0;
        r = (sel == 2) ? r2 : r0;
        z = (sel == 2) ? dbz2 : dbz0;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;   // DONE -> IDLE
  endtask

  typedef struct {
    int           sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic         exp_z;
    int           exp_lat;
  } vec_t;

  vec_t vecs[8];

  logic [W-1:0] q, r;
  logic         z;
  int           lat, nbusy, overlap;
  int           done_cnt;
  int           done_at[$];
  int           ia, ib;

  initial begin
    vecs[0] = '{0, 8'd200, 8'd7,   8'd28,  8'd4, 1'b0, 9};
    vecs[1] = '{0, 8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 9};
    vecs[2] = '{0, 8'd5,   8'd9,   8'd0,   8'd5, 1'b0, 9};
    vecs[3] = '{0, 8'd255, 8'd255, 8'd1,   8'd0, 1'b0, 9};
    vecs[4] = '{0, 8'd7,   8'd0,   8'd255, 8'd7, 1'b1, 1};
    vecs[5] = '{0, 8'd9,   8'd3,   8'd3,   8'd0, 1'b0, 9};
    vecs[6] = '{2, 8'd200, 8'd7,   8'd28,  8'd1, 1'b0, 7};
    vecs[7] = '{2, 8'd13,  8'd2,   8'd4,   8'd1, 1'b0, 7};

    rst = 1'b1; start0 = 1'b0; start2 = 1'b0; dividend = '0; divisor = '0;
    @(posedge clk); #1;
    start0 = 1'b1;           // reset must win over start on the same edge
    @(posedge clk); #1;
    check("reset_busy0", busy0, 0);
    check("reset_done0", done0, 0);
    check("reset_q0",    q0,    0);
    check("reset_r0",    r0,    0);
    check("reset_dbz0",  dbz0,  0);
    check("reset_busy2", busy2, 0);
    start0 = 1'b0;
    rst    = 1'b0;
    @(posedge clk); #1;

    // Directed table
    foreach (vecs[i]) begin
      do_op(vecs[i].sel, vecs[i].a, vecs[i].b, q, r, z, lat, nbusy, overlap);
      check($sformatf("vec%0d_q", i),       q,       vecs[i].exp_q);
      check($sformatf("vec%0d_r", i),       r,       vecs[i].exp_r);
      check($sformatf("vec%0d_dbz", i),     z,       vecs[i].exp_z);
      check($sformatf("vec%0d_lat", i),     lat,     vecs[i].exp_lat);
      check($sformatf("vec%0d_busy", i),    nbusy,   vecs[i].exp_lat - 1);
      check($sformatf("vec%0d_overlap", i), overlap, 0);
    end

    // Reset abort: second start during CALC is ignored, reset clears everything
    dividend = 8'd100; divisor = 8'd3; start0 = 1'b1;
    @(posedge clk); #1;                    // cycle 1
    start0 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end   // cycle 4
    dividend = 8'd1; divisor = 8'd1; start0 = 1'b1;
    @(posedge clk); #1;                    // cycle 5
    check("abort_busy_c5", busy0, 1);
    @(posedge clk); #1;                    // cycle 6
    rst = 1'b1; start0 = 1'b0;
    @(posedge clk); #1;                    // cycle 7, after reset edge
    rst = 1'b0;
    check("abort_busy", busy0, 0);
    check("abort_q",    q0,    0);
    check("abort_r",    r0,    0);
    check("abort_dbz",  dbz0,  0);
    done_cnt = 0;
    for (int n = 0; n < 15; n++) begin
      if (done0 || busy0) done_cnt++;
      @(posedge clk); #1;
    end
    check("abort_no_done", done_cnt, 0);
    do_op(0, 8'd100, 8'd3, q, r, z, lat, nbusy, overlap);
    check("after_abort_q", q, 33);
    check("after_abort_r", r, 1);

    // start held high: back-to-back operations, one per W-K+2 cycles
    dividend = 8'd20; divisor = 8'd3; start0 = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (done0) done_at.push_back(n);
      if (done_at.size() == 2) begin
        start0 = 1'b0;
        break;
      end
    end
    start0 = 1'b0;
    check("b2b_dones", done_at.size(), 2);
    if (done_at.size() == 2) begin
      check("b2b_first",  done_at[0], 9);
      check("b2b_period", done_at[1] - done_at[0], 10);
      check("b2b_q", q0, 6);
      check("b2b_r", r0, 2);
    end
    repeat (2) begin @(posedge clk); #1; end

    // Randomized, K = 0: exact division identities
    for (int i = 0; i < 1000; i++) begin
      ia = int'($urandom_range(0, 255));
      ib = int'($urandom_range(1, 255));
      do_op(0, W'(ia), W'(ib), q, r, z, lat, nbusy, overlap);
      check($sformatf("rand_k0_ident a=%0d b=%0d", ia, ib), int'(q) * ib + int'(r), ia);
      check($sformatf("rand_k0_rlt a=%0d b=%0d", ia, ib), (int'(r) < ib) && (lat == 9) && !z, 1);
    end

    // Randomized, K = 2: quotient of a>>2 rescaled, remainder of a>>2
    for (int i = 0; i < 300; i++) begin
      ia = int'($urandom_range(0, 255));
      ib = int'($urandom_range(1, 255));
      do_op(2, W'(ia), W'(ib), q, r, z, lat, nbusy, overlap);
      check($sformatf("rand_k2_q a=%0d b=%0d", ia, ib), q, ((ia / 4) / ib) * 4);
      check($sformatf("rand_k2_r a=%0d b=%0d", ia, ib), r, (ia / 4) % ib);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
